// File: rtl/apb_master_gen2_if.sv
// Request/response and APB bus bundle for apb_master_gen2.
// master = the bridge side, slave = requester plus APB completer side.
interface apb_master_gen2_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_strb;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_addr, req_write,
    input  req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output rsp_timeout,
    output psel, penable, paddr, pwrite,
    output pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write,
    output req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  rsp_timeout,
    input  psel, penable, paddr, pwrite,
    input  pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_gen2.sv
// Single-request APB master with registered bus outputs
// and an optional ACCESS-phase wait timeout.
module apb_master_gen2 #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic pclk,
  input logic presetn,
  apb_master_gen2_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] LIMIT =
    (CNT_W+1)'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] cnt_inc;
  logic accept, done, abort, expired;

  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  // this ACCESS cycle would be the TIMEOUT-th without pready
  assign expired = (TIMEOUT != 0) && (cnt_inc >= LIMIT);
  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == ACCESS && !bus.pready
                 && cnt != '1) begin
      cnt <= cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.paddr   <= {ADDR_W{1'b0}};
      bus.pwrite  <= 1'b0;
      bus.pwdata  <= {DATA_W{1'b0}};
      bus.pstrb   <= {STRB_W{1'b0}};
    end else begin
      bus.psel    <= (state_n == SETUP)
                  || (state_n == ACCESS);
      bus.penable <= (state_n == ACCESS);
      if (accept) begin
        bus.paddr  <= bus.req_addr;
        bus.pwrite <= bus.req_write;
        bus.pwdata <= bus.req_write
                    ? bus.req_wdata : {DATA_W{1'b0}};
        bus.pstrb  <= bus.req_write
                    ? bus.req_strb : {STRB_W{1'b0}};
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_W{1'b0}};
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= done | abort;
      if (done) begin
        bus.rsp_err     <= bus.pslverr;
        bus.rsp_timeout <= 1'b0;
        bus.rsp_rdata   <= (!bus.pwrite && !bus.pslverr)
                         ? bus.prdata : {DATA_W{1'b0}};
      end else if (abort) begin
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
        bus.rsp_rdata   <= {DATA_W{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_apb_master_gen2.sv
// Bench for apb_master_gen2: transaction model, scripted
// APB completer and directed request sequences.
module tb_apb_master_gen2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_master_gen2_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_master_gen2 #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .pclk(clk),
    .presetn(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // scripted completer: pready after slave_wait low cycles
  int slave_wait = 0;
  logic [31:0] slave_rdata = '0;
  logic slave_err = 1'b0;
  int acc_n = 0;

  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      bus.pready  = (acc_n >= slave_wait);
      bus.prdata  = slave_rdata;
      bus.pslverr = slave_err;
      acc_n++;
    end else begin
      // junk outside ACCESS must be ignored
      bus.pready  = bus.psel;
      bus.pslverr = bus.psel;
      bus.prdata  = 32'hBAD0BAD0;
      acc_n = 0;
    end
  end

  // transaction-level model
  bit m_busy = 0;
  int m_phase = 0;
  logic [7:0]  m_addr = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;
  logic        m_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_phase = 0;
      m_addr = '0; m_write = 1'b0;
      m_wdata = '0; m_strb = '0;
      m_rv = 1'b0; m_rd = '0;
      m_err = 1'b0; m_to = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy  = 1;
          m_phase = 0;
          m_addr  = bus.req_addr;
          m_write = bus.req_write;
          m_wdata = bus.req_write ? bus.req_wdata : '0;
          m_strb  = bus.req_write ? bus.req_strb : '0;
        end
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (bus.pready) begin
        m_busy = 0;
        m_rv   = 1'b1;
        m_err  = bus.pslverr;
        m_to   = 1'b0;
        m_rd   = (m_write || bus.pslverr)
               ? 32'h0 : bus.prdata;
      end else if (TO > 0 && m_phase >= TO) begin
        m_busy = 0;
        m_rv = 1'b1; m_err = 1'b1;
        m_to = 1'b1; m_rd = '0;
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", bus.req_ready, !m_busy);
    chk("psel", bus.psel, m_busy);
    chk("penable", bus.penable, m_busy && m_phase >= 1);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("rsp_rdata", bus.rsp_rdata, m_rd);
    chk("rsp_err", bus.rsp_err, m_err);
    chk("rsp_timeout", bus.rsp_timeout, m_to);
    if (m_busy) begin
      chk("paddr", bus.paddr, m_addr);
      chk("pwrite", bus.pwrite, m_write);
      chk("pwdata", bus.pwdata, m_wdata);
      chk("pstrb", bus.pstrb, m_strb);
    end
  end

  task automatic send(input logic [7:0] a,
                      input logic w,
                      input logic [31:0] d,
                      input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_wdata = d;
    bus.req_strb  = s;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int acc,
                          output logic [31:0] rd,
                          output logic err,
                          output logic to);
    int n = 0;
    acc = 0;
    do begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++;
      n++;
    end while (!bus.rsp_valid && n < 60);
    chk("rsp_wait", bus.rsp_valid, 1);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    to  = bus.rsp_timeout;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic [31:0] rd;
    logic err, to;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", bus.psel, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_paddr", bus.paddr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write, zero wait
    slave_wait = 0;
    send(8'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    chk("w_setup_psel", bus.psel, 1);
    chk("w_setup_penable", bus.penable, 0);
    chk("w_pwdata", bus.pwdata, 32'hDEADBEEF);
    wait_rsp(acc, rd, err, to);
    chk("w_access_cycles", acc, 1);
    chk("w_rdata", rd, 0);
    chk("w_err", err, 0);

    // read, 3 wait states
    slave_wait = 3;
    slave_rdata = 32'h12345678;
    send(8'h24, 1'b0, 32'hFFFFFFFF, 4'hF);
    chk("r_pstrb", bus.pstrb, 0);
    chk("r_pwdata", bus.pwdata, 0);
    wait_rsp(acc, rd, err, to);
    chk("r_access_cycles", acc, 4);
    chk("r_rdata", rd, 32'h12345678);
    chk("r_err", err, 0);

    // slave error on read
    slave_wait = 0;
    slave_err = 1'b1;
    slave_rdata = 32'hCAFEF00D;
    send(8'h30, 1'b0, 32'h0, 4'h0);
    wait_rsp(acc, rd, err, to);
    chk("se_err", err, 1);
    chk("se_timeout", to, 0);
    chk("se_rdata", rd, 0);
    slave_err = 1'b0;

    // timeout: pready never rises
    slave_wait = 1000;
    send(8'h40, 1'b1, 32'h11112222, 4'h3);
    wait_rsp(acc, rd, err, to);
    chk("to_access_cycles", acc, 4);
    chk("to_err", err, 1);
    chk("to_timeout", to, 1);
    chk("to_rdata", rd, 0);
    chk("to_psel_rsp", bus.psel, 0);
    @(negedge clk);
    chk("to_psel_after", bus.psel, 0);

    // pready on the 4th ACCESS cycle completes normally
    slave_wait = 3;
    send(8'h44, 1'b1, 32'h33334444, 4'h5);
    wait_rsp(acc, rd, err, to);
    chk("edge_access_cycles", acc, 4);
    chk("edge_err", err, 0);
    chk("edge_timeout", to, 0);

    // back-to-back with req_valid held high
    slave_wait = 0;
    slave_rdata = 32'h0BADCAFE;
    @(negedge clk);
    bus.req_addr  = 8'h50;
    bus.req_write = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_addr  = 8'h60;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h5A5A5A5A;
    bus.req_strb  = 4'hC;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 20);
    chk("b2b_rsp1", bus.rsp_valid, 1);
    chk("b2b_ready_in_rsp", bus.req_ready, 1);
    chk("b2b_paddr_hold", bus.paddr, 8'h50);
    chk("b2b_rdata1", bus.rsp_rdata, 32'h0BADCAFE);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("b2b_paddr_new", bus.paddr, 8'h60);
    chk("b2b_setup_psel", bus.psel, 1);
    chk("b2b_setup_penable", bus.penable, 0);
    wait_rsp(acc, rd, err, to);
    chk("b2b_access_cycles", acc, 1);
    chk("b2b_rdata2", rd, 0);

    // reset during ACCESS
    slave_wait = 1000;
    send(8'h70, 1'b0, 32'h0, 4'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.penable && n < 10);
    chk("rst_mid_access", bus.penable, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", bus.psel, 0);
    chk("rst_mid_penable", bus.penable, 0);
    chk("rst_mid_rsp", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", bus.req_ready, 1);
    repeat (3) @(negedge clk);

    // normal read after reset
    slave_wait = 1;
    slave_rdata = 32'hA5A5A5A5;
    send(8'h7C, 1'b0, 32'h0, 4'h0);
    wait_rsp(acc, rd, err, to);
    chk("post_access_cycles", acc, 2);
    chk("post_rdata", rd, 32'hA5A5A5A5);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
